// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end.
//
// The unit issues word-aligned fetch requests to instruction memory. Returned words go into a
// small instruction buffer, tagged with their PC, and the datapath drains that buffer.
// A request is issued only when buffer space is already reserved for its response. Memory
// responses therefore never need back-pressure.
//
// On a redirect (taken branch/jump), the unit does the following:
//   - the buffer is flushed;
//   - the responses still in flight are counted and dropped as they arrive;
//   - fetch restarts at the new word-aligned address.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   redirect_valid/redirect_pc  flush and refetch from redirect_pc (bits [1:0] ignored)
//   imem_req_valid/ready/addr   fetch request handshake and word-aligned address
//   imem_resp_valid/data        in-order, never-stalled memory responses
//   instr_valid/ready           buffer head handshake towards the datapath
//   instruction/instr_pc        buffer head word and its address (0 when empty)
module ifetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [63:0] instr_pc
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_W = OW'(FIFO_DEPTH);
    localparam logic [63:0] WORD_MASK = ~64'h3;

    // State
    logic          run_q, run_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pcq_wr_q, pcq_wr_d;
    logic [PW-1:0] pcq_rd_q, pcq_rd_d;

    // Storage: instruction buffer (word + PC) and the PC-tracking queue of live requests
    logic [31:0] data_mem [FIFO_DEPTH];
    logic [63:0] pc_mem   [FIFO_DEPTH];
    logic [63:0] pcq_mem  [FIFO_DEPTH];

    logic          req_xfer;
    logic          resp_seen;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic [OW-1:0] occupancy;

    always_comb begin
        occupancy = {1'b0, outstanding_q} + {1'b0, count_q};
        // Issue only while every outstanding response has a reserved buffer slot.
        imem_req_valid = run_q && !redirect_valid && (occupancy < DEPTH_W);
        imem_req_addr  = fetch_pc_q & WORD_MASK;
        req_xfer       = imem_req_valid && imem_req_ready;

        // The guard keeps a stray response from wrapping the counters.
        resp_seen = imem_resp_valid && (outstanding_q != '0);
        // Responses already in flight at a redirect, or arriving in its cycle, are stale.
        resp_drop = resp_seen && (redirect_valid || (discard_q != '0));
        push      = resp_seen && !resp_drop;

        instr_valid = (count_q != '0);
        pop         = instr_valid && instr_ready;
        instruction = instr_valid ? data_mem[rd_ptr_q] : 32'h0;
        instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : 64'h0;
    end

    always_comb begin
        run_d         = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(req_xfer) - CW'(resp_seen);
        discard_d     = discard_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pcq_wr_d      = pcq_wr_q;
        pcq_rd_d      = pcq_rd_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & WORD_MASK;
            // Everything still in flight belongs to the old path.
            discard_d  = outstanding_q - CW'(resp_seen);
            // A pop this cycle was consumed by the datapath; all else is flushed.
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pcq_wr_d   = '0;
            pcq_rd_d   = '0;
        end else begin
            if (req_xfer) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
                pcq_wr_d   = pcq_wr_q + PW'(1);
            end
            if (resp_drop) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                pcq_rd_d = pcq_rd_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
        end else begin
            run_q         <= run_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
        end
    end

    // Storage arrays need no reset; valid state lives entirely in the counters and pointers.
    always_ff @(posedge clk) begin
        if (req_xfer) begin
            pcq_mem[pcq_wr_q] <= imem_req_addr;
        end
        if (push && !redirect_valid) begin
            data_mem[wr_ptr_q] <= imem_resp_data;
            pc_mem[wr_ptr_q]   <= pcq_mem[pcq_rd_q];
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed self-checking bench for ifetch_unit.
// The memory model returns responses in order after a programmable latency. The data word is
// derived from the address, so delivered words can be checked against their PC.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [63:0] instr_pc;

    // Second instance for the PC wrap-around case
    logic        w_req_valid;
    logic [63:0] w_req_addr;
    logic        w_instr_valid;
    logic [31:0] w_instruction;
    logic [63:0] w_instr_pc;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int lat   = 1;

    logic [63:0] req_log[$];
    logic [63:0] w_log[$];
    logic [63:0] dl_pc[$];
    logic [63:0] dl_ins[$];
    logic [63:0] pend_addr[$];
    int          pend_due[$];

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(4)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    ifetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .FIFO_DEPTH(4)) u_dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (1'b0),
        .redirect_pc    (64'h0),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (1'b1),
        .imem_req_addr  (w_req_addr),
        .imem_resp_valid(1'b0),
        .imem_resp_data (32'h0),
        .instr_valid    (w_instr_valid),
        .instr_ready    (1'b0),
        .instruction    (w_instruction),
        .instr_pc       (w_instr_pc)
    );

    function automatic logic [31:0] data_of(input logic [63:0] a);
        return a[31:0] + 32'h00C0_0293;
    endfunction

    function automatic logic [63:0] qget(input logic [63:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then drive memory responses after the
    // rising edge.
    task automatic tick();
        int due;
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
            due = cyc + lat;
            if (pend_due.size() > 0 && due <= pend_due[$]) due = pend_due[$] + 1;
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(due);
        end
        if (instr_valid && instr_ready) begin
            dl_pc.push_back(instr_pc);
            dl_ins.push_back({32'h0, instruction});
        end
        if (w_req_valid) w_log.push_back(w_req_addr);
        @(posedge clk);
        #1;
        cyc++;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = data_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        #1;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        #1;
        repeat (3) tick();
    endtask

    // Abandon memory traffic, release mid-cycle, then run through the first rising edge.
    task automatic release_reset();
        pend_addr.delete();
        pend_due.delete();
        req_log.delete();
        dl_pc.delete();
        dl_ins.delete();
        imem_resp_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        tick();
    endtask

    task automatic do_reset();
        hold_reset();
        release_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'h0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;    // responses during reset must be ignored
        imem_resp_data  = 32'hDEAD_BEEF;
        instr_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
        check("rst_instruction", {32'h0, instruction}, 64'h0);
        check("rst_instr_pc", instr_pc, 64'h0);
        imem_resp_valid = 1'b0;

        // Scenario 1: streaming with 1-cycle memory latency
        lat = 1;
        instr_ready = 1'b1;
        do_reset();
        check("s1_first_valid", {63'h0, imem_req_valid}, 64'h1);
        check("s1_first_addr", imem_req_addr, 64'h0);
        tick();
        check("s1_no_bypass", {63'h0, instr_valid}, 64'h0);
        tick();
        check("s1_latency_valid", {63'h0, instr_valid}, 64'h1);
        check("s1_head_instr", {32'h0, instruction}, 64'h00C0_0293);
        check("s1_head_pc", instr_pc, 64'h0);
        repeat (8) tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("s1_req%0d", i), qget(req_log, i), 64'(4 * i));
            check($sformatf("s1_pc%0d", i), qget(dl_pc, i), 64'(4 * i));
            check($sformatf("s1_ins%0d", i), qget(dl_ins, i), {32'h0, data_of(64'(4 * i))});
        end

        // Scenario 5: wrap-around instance, no responses so it stops after four requests
        check("s5_count", 64'(w_log.size()), 64'd4);
        check("s5_a0", qget(w_log, 0), 64'hFFFF_FFFF_FFFF_FFF8);
        check("s5_a1", qget(w_log, 1), 64'hFFFF_FFFF_FFFF_FFFC);
        check("s5_a2", qget(w_log, 2), 64'h0);
        check("s5_a3", qget(w_log, 3), 64'h4);
        check("s5_stopped", {63'h0, w_req_valid}, 64'h0);

        // Scenario 2: datapath stalled, buffer fills to exactly FIFO_DEPTH
        instr_ready = 1'b0;
        do_reset();
        repeat (15) tick();
        check("s2_req_count", 64'(req_log.size()), 64'd4);
        check("s2_req3", qget(req_log, 3), 64'hC);
        check("s2_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("s2_instr_valid", {63'h0, instr_valid}, 64'h1);
        check("s2_head_pc", instr_pc, 64'h0);
        check("s2_head_instr", {32'h0, instruction}, 64'h00C0_0293);
        repeat (3) tick();
        check("s2_head_pc_held", instr_pc, 64'h0);
        instr_ready = 1'b1;
        repeat (12) tick();
        check("s2_drain_pc3", qget(dl_pc, 3), 64'hC);
        check("s2_drain_pc4", qget(dl_pc, 4), 64'h10);
        check("s2_drain_ins4", qget(dl_ins, 4), {32'h0, data_of(64'h10)});

        // Scenario 3: redirect with two requests in flight
        lat = 3;
        do_reset();
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        #1;
        check("s3_no_req_redirect", {63'h0, imem_req_valid}, 64'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("s3_next_valid", {63'h0, imem_req_valid}, 64'h1);
        check("s3_next_addr", imem_req_addr, 64'h100);
        repeat (10) tick();
        check("s3_req2", qget(req_log, 2), 64'h100);
        check("s3_pc0", qget(dl_pc, 0), 64'h100);
        check("s3_ins0", qget(dl_ins, 0), {32'h0, data_of(64'h100)});
        check("s3_pc1", qget(dl_pc, 1), 64'h104);

        // Second redirect while still discarding: latest target wins
        do_reset();
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        tick();
        redirect_pc    = 64'h305;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("s3b_next_addr", imem_req_addr, 64'h304);
        repeat (10) tick();
        check("s3b_req2", qget(req_log, 2), 64'h304);
        check("s3b_pc0", qget(dl_pc, 0), 64'h304);
        check("s3b_ins0", qget(dl_ins, 0), {32'h0, data_of(64'h304)});

        // Scenario 4: memory not ready for 3 cycles
        lat = 1;
        do_reset();
        repeat (2) tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("s4_hold_addr%0d", i), imem_req_addr, 64'h8);
            check($sformatf("s4_hold_valid%0d", i), {63'h0, imem_req_valid}, 64'h1);
        end
        imem_req_ready = 1'b1;
        tick();
        check("s4_resume_addr", imem_req_addr, 64'hC);
        check("s4_req_count", 64'(req_log.size()), 64'd3);
        repeat (6) tick();
        check("s4_pc2", qget(dl_pc, 2), 64'h8);
        check("s4_pc3", qget(dl_pc, 3), 64'hC);

        // Scenario 6: reset with buffer occupied and requests outstanding
        lat = 3;
        instr_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        check("s6_pre_valid", {63'h0, instr_valid}, 64'h1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("s6_rst_instr_valid", {63'h0, instr_valid}, 64'h0);
        check("s6_rst_instruction", {32'h0, instruction}, 64'h0);
        check("s6_rst_instr_pc", instr_pc, 64'h0);
        repeat (3) tick();
        pend_addr.delete();
        pend_due.delete();
        req_log.delete();
        dl_pc.delete();
        dl_ins.delete();
        imem_resp_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("s6_pre_edge_valid", {63'h0, imem_req_valid}, 64'h0);
        tick();
        check("s6_restart_valid", {63'h0, imem_req_valid}, 64'h1);
        check("s6_restart_addr", imem_req_addr, 64'h0);
        check("s6_no_stale", {63'h0, instr_valid}, 64'h0);
        lat = 1;
        instr_ready = 1'b1;
        repeat (8) tick();
        check("s6_pc0", qget(dl_pc, 0), 64'h0);
        check("s6_ins0", qget(dl_ins, 0), {32'h0, data_of(64'h0)});
        check("s6_pc1", qget(dl_pc, 1), 64'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16), giving the instruction buffer depth.
REQ-003 Clock and reset SHALL be: one clock, reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 redirect_valid  input  1  taken branch/jump from the datapath; flush and refetch.
REQ-007 redirect_pc  input  64  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-010 imem_req_addr  output  64  fetch address, word aligned.
REQ-011 imem_resp_valid  input  1  in-order response valid; memory never stalls responses.
REQ-012 imem_resp_data  input  32  fetched instruction word.
REQ-013 instr_valid  output  1  buffer head holds a valid instruction.
REQ-014 instr_ready  input  1  datapath consumes the head this cycle.
REQ-015 instruction  output  32  head instruction word, feeds the datapath instruction port.
REQ-016 instr_pc  output  64  address of the head instruction.

Function
REQ-017 A request SHALL transfer on any cycle with imem_req_valid && imem_req_ready; the fetch PC then advances by 4, modulo 2^64.
REQ-018 imem_req_valid SHALL be 1 only if outstanding + fifo_count < FIFO_DEPTH, so every response has guaranteed buffer space.
REQ-019 imem_req_addr SHALL stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-020 The outstanding counter SHALL increment on a request transfer and decrement on imem_resp_valid; both in one cycle leave it unchanged.
REQ-021 A non-discarded response SHALL be written into the FIFO with its PC, taken from a PC-tracking queue in request order; instr_valid SHALL rise the next cycle (1-cycle response-to-output latency).
REQ-022 The FIFO SHALL support a push and a pop in the same cycle, including when it is full or empty (an empty FIFO does not bypass).
REQ-023 instruction and instr_pc SHALL hold steady while instr_valid=1 and instr_ready=0.
REQ-024 On redirect_valid the FIFO SHALL be emptied, and no request SHALL be issued that cycle. From the next cycle, fetch SHALL resume at {redirect_pc[63:2],2'b00}.
REQ-025 On redirect, a discard counter SHALL be loaded with the in-flight request count. Responses SHALL be dropped while the discard counter is nonzero, and each dropped response decrements it.
REQ-026 A response arriving in the redirect cycle SHALL be dropped and counted against the discard load. A pop in the redirect cycle SHALL take effect normally, and the remaining entries are flushed.
REQ-027 A second redirect while discarding SHALL reload the discard counter with the current in-flight count; the latest redirect_pc wins.
REQ-028 Dropped responses SHALL NOT produce instr_valid and SHALL NOT consume buffer space.

Reset
REQ-029 While rst_n=0: imem_req_valid=0, instr_valid=0, instruction=32'h0, instr_pc=64'h0, FIFO empty, outstanding=0, discard=0, fetch PC=RESET_PC.
REQ-030 On the first rising edge after rst_n deasserts, imem_req_valid=1 with imem_req_addr=RESET_PC.
REQ-031 Reset asserted mid-operation SHALL abandon all in-flight requests. Responses arriving while reset is asserted SHALL be ignored.

Verification
REQ-032 Scenario 1: reset, then ready=1 with a 1-cycle response latency and instr_ready=1. Required response: request addresses 0,4,8,C; instruction 32'h00C00293 appears with instr_pc=0, and the following instructions appear in order.
REQ-033 Scenario 2: instr_ready=0 with ready=1. Required response: exactly FIFO_DEPTH requests are issued (0..C), then imem_req_valid=0; instr_valid=1 is held with instr_pc=0 unchanged.
REQ-034 Scenario 3: with 2 requests in flight, pulse redirect_valid with redirect_pc=64'h103. Required response: the next 2 responses are dropped; the next request address is 64'h100; the first delivered instr_pc is 64'h100.
REQ-035 Scenario 4: imem_req_ready=0 for 3 cycles. Required response: imem_req_addr is held, and no PC advance occurs.
REQ-036 Scenario 5: RESET_PC=64'hFFFF_FFFF_FFFF_FFF8. Required response: request addresses are ...FFF8, ...FFFC, 0, 4 (wrap-around).
REQ-037 Scenario 6: assert rst_n=0 with the FIFO full and 2 requests outstanding. Required response: all outputs return to their reset values, and after release the fetch restarts at RESET_PC with no stale instruction delivered.
